// File: rtl/hv_stream_loader.sv
// -----------------------------------------------------------------------------
// hv_stream_loader
//
// Purpose:
//   Reassembles a hypervector of DIM+1 bits from a stream of 32-bit words and
//   presents it to the core array under a valid/ready handshake. Two vector
//   registers are used: an assembly register that fills from the stream and a
//   holding register that drives hv_d. While the holding register is busy, one
//   further vector may be completed in the assembly register. The stream is
//   then stalled until the core array takes the presented vector.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       asynchronous reset, active low
//   src_v      in   1       stream word valid
//   src_d      in   32      stream word data
//   src_last   in   1       final word of a vector (used only with frame check)
//   src_ready  out  1       loader accepts a word this cycle
//   hv_v       out  1       hv_d holds a complete vector
//   hv_ready   in   1       core array consumes hv_d
//   hv_d       out  DIM+1   assembled vector
//   word_i     out  IW      index of the next word to be written
//   err        out  1       sticky framing error
//
// Word k of a vector lands in bits [32k+31:32k].
//
// Optional feature (macro HV_LOADER_FRAME_CHECK_EN):
//   src_last is checked on every accepted word. An early last closes the
//   vector with the remaining words zero-filled. A missing last on the final
//   word still completes the vector. Both cases set the sticky err flag.
//   Without the macro, src_last is ignored and err stays 0.
// -----------------------------------------------------------------------------
module hv_stream_loader #(
  parameter int DIM   = 1023,
  parameter int WORDS = (DIM + 1) / 32,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_v,
  input  logic [31:0]   src_d,
  input  logic          src_last,
  output logic          src_ready,
  input  logic          hv_ready,
  output logic          hv_v,
  output logic [DIM:0]  hv_d,
  output logic [IW-1:0] word_i,
  output logic          err
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e        state_q, state_d;
  logic          src_ready_q, src_ready_d;
  logic          hv_v_q, hv_v_d;
  logic [DIM:0]  hv_d_q, hv_d_d;
  logic [DIM:0]  asm_q, asm_d;
  logic [IW-1:0] word_q, word_d;
  logic          err_q, err_d;

  logic          xfer_s;
  logic          last_word_s;
  logic          frame_end_s;
  logic          frame_err_s;
  logic          done_s;
  logic          consume_s;
  logic [DIM:0]  merged_s;

  assign xfer_s      = src_v & src_ready_q;
  assign last_word_s = (word_q == LAST_IDX);
  assign consume_s   = hv_v_q & hv_ready;

`ifdef HV_LOADER_FRAME_CHECK_EN
  // A vector ends on the word-count limit or on src_last, whichever comes first.
  // Disagreement between the two is a framing error.
  assign frame_end_s = src_last | last_word_s;
  assign frame_err_s = xfer_s & (src_last ^ last_word_s);
`else
  logic unused_src_last_s;
  assign unused_src_last_s = src_last;
  assign frame_end_s       = last_word_s;
  assign frame_err_s       = 1'b0;
`endif

  assign done_s = xfer_s & frame_end_s;

  // Assembly register with the current stream word written into slot word_q.
  // The assembly register is cleared whenever its contents move out. This keeps
  // unwritten slots at zero, which provides the zero-fill after an early last.
  always_comb begin
    merged_s = asm_q;
    for (int w = 0; w < WORDS; w++) begin
      if (word_q == IW'(w)) begin
        merged_s[32*w +: 32] = src_d;
      end else begin
        merged_s[32*w +: 32] = asm_q[32*w +: 32];
      end
    end
  end

  // Next-state decode for the fill/hold FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    hv_v_d  = hv_v_q;
    hv_d_d  = hv_d_q;
    asm_d   = asm_q;
    word_d  = word_q;
    err_d   = err_q | frame_err_s;

    case (state_q)
      FILL: begin
        if (done_s) begin
          word_d = {IW{1'b0}};
          if (!hv_v_q || hv_ready) begin
            // Holding register is free or drains on this edge: hand over directly.
            hv_d_d = merged_s;
            hv_v_d = 1'b1;
            asm_d  = {(DIM+1){1'b0}};
          end else begin
            // Park the completed vector and stall the stream.
            asm_d   = merged_s;
            state_d = HOLD;
          end
        end else if (xfer_s) begin
          asm_d  = merged_s;
          word_d = word_q + IW'(1);
          if (consume_s) begin
            hv_v_d = 1'b0;
          end else begin
            hv_v_d = hv_v_q;
          end
        end else begin
          if (consume_s) begin
            hv_v_d = 1'b0;
          end else begin
            hv_v_d = hv_v_q;
          end
        end
      end

      HOLD: begin
        if (consume_s) begin
          hv_d_d  = asm_q;
          hv_v_d  = 1'b1;
          asm_d   = {(DIM+1){1'b0}};
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    src_ready_d = (state_d == FILL);
  end

  // State and output registers. The asynchronous reset clears everything,
  // including any partially assembled vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      src_ready_q <= 1'b0;
      hv_v_q      <= 1'b0;
      hv_d_q      <= {(DIM+1){1'b0}};
      asm_q       <= {(DIM+1){1'b0}};
      word_q      <= {IW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ready_q <= src_ready_d;
      hv_v_q      <= hv_v_d;
      hv_d_q      <= hv_d_d;
      asm_q       <= asm_d;
      word_q      <= word_d;
      err_q       <= err_d;
    end
  end

  assign src_ready = src_ready_q;
  assign hv_v      = hv_v_q;
  assign hv_d      = hv_d_q;
  assign word_i    = word_q;
  assign err       = err_q;

endmodule
